roce_write_segmenter: RTL and testbench
=======================================

# roce_write_segmenter

Splits one RDMA WRITE DMA request into a sequence of per-packet RoCEv2 RC work descriptors of at most one PMTU each. It sits directly downstream of the UDP RoCE connection manager, consuming its `start_transfer`, `dma_transfer`, `rem_addr`, `r_key`, `rem_qpn` and `rem_psn` outputs. It feeds the BTH/RETH header builder through a valid/ready descriptor stream. It assigns opcode, PSN, remote address and payload length to every packet and reports the PSN to use for the next transfer.

## Interface
- `PMTU_LOG2`, default 12: log2 of the path MTU in bytes; legal values 8..12 (256..4096 B).
- `clk` input 1: clock.
- `rst` input 1: reset; asynchronous, active-high.
- `start_transfer` input 1: one-cycle request strobe; sampled only when `busy`=0.
- `dma_length` input 32: total bytes to write.
- `rem_addr` input 64: remote virtual address of the first byte.
- `r_key` input 32: remote key.
- `rem_qpn` input 24: destination QP number.
- `start_psn` input 24: PSN of the first packet.
- `m_wr_valid` output 1: descriptor valid.
- `m_wr_ready` input 1: descriptor accepted by downstream.
- `m_wr_opcode` output 8: 0x06 FIRST, 0x07 MIDDLE, 0x08 LAST, 0x0A ONLY.
- `m_wr_psn` output 24: packet PSN.
- `m_wr_addr` output 64: remote address of this packet's payload.
- `m_wr_reth_len` output 32: `dma_length` of the transfer; meaningful for FIRST/ONLY.
- `m_wr_r_key` output 32: latched `r_key`.
- `m_wr_qpn` output 24: latched `rem_qpn`.
- `m_wr_pay_len` output 13: payload bytes of this packet (0..4096).
- `m_wr_ack_req` output 1: BTH AckReq bit; set on LAST and ONLY.
- `psn_next` output 24: PSN following the last packet of the most recent completed transfer.
- `done` output 1: one-cycle completion pulse.
- `busy` output 1: transfer in progress.

## Operation
- States: IDLE, ISSUE.
- **IDLE.** On `start_transfer`=1, latch all request inputs and compute the remaining length, then go to ISSUE.
  - Remaining = `dma_length`; packet address = `rem_addr`; PSN = `start_psn`; `first` flag = 1.
- **ISSUE.** Present a descriptor built from the current state.
  - Payload length: `m_wr_pay_len` = min(remaining, 2^PMTU_LOG2).
  - Last packet: `last` = (remaining ≤ 2^PMTU_LOG2).
  - Opcode: first&last → ONLY; first only → FIRST; last only → LAST; otherwise MIDDLE.
- **On handshake** (`m_wr_valid`&`m_wr_ready`):
  - remaining -= payload length; address += payload length (64-bit, wraps mod 2^64); PSN += 1 (mod 2^24); `first` = 0.
  - If `last`: update `psn_next` to the incremented PSN, pulse `done`, return to IDLE.
- `dma_length`=0 produces one ONLY descriptor with `m_wr_pay_len`=0.
- `dma_length` an exact multiple of the PMTU: the final packet is LAST (or ONLY) with full PMTU length. No empty trailing packet is emitted.
- Arithmetic:
  - Remaining counter is 32 bits.
  - Packet count is ceil(len/PMTU), or 1 when len=0.
- `start_transfer` while `busy`=1 is ignored and has no side effects.

## Timing
- Reset values:
  - Outputs: `m_wr_valid`=0, `done`=0, `busy`=0, `psn_next`=0, all descriptor fields=0.
  - State: IDLE.
- Reset acts immediately and asynchronously. Asserting `rst` mid-transfer drops `m_wr_valid` the same instant and abandons the transfer without a `done` pulse.
- Start latency:
  - `start_transfer` sampled at edge N.
  - `busy`=1 and `m_wr_valid`=1 with the first descriptor from edge N+1.
- Back-to-back: with `m_wr_ready` held high, one descriptor is accepted per cycle, with no bubbles between packets.
- Hold rule: while `m_wr_valid`=1 and `m_wr_ready`=0, every `m_wr_*` field holds stable. `m_wr_valid` never drops without a handshake, except on reset.
- Completion: at the edge of the final handshake:
  - `m_wr_valid`→0, `busy`→0, `done`→1 for one cycle, `psn_next` updated.
  - A `start_transfer` in that same `done` cycle is accepted.
- `m_wr_ready` is ignored while `m_wr_valid`=0.
- No combinational path from `m_wr_ready` to any output.

## Test plan
- **Single packet:** PMTU_LOG2=12, `dma_length`=0x1000, `rem_addr`=0x1_0000_0000, `start_psn`=0x10 → one descriptor.
  - Fields: ONLY (0x0A), psn 0x10, addr 0x1_0000_0000, pay_len 4096, ack_req 1.
  - Then `done`=1 and `psn_next`=0x11.
- **Multi-packet:** `dma_length`=10000, PMTU_LOG2=12, `rem_addr`=0x2000, `start_psn`=5 → three descriptors.
  - FIRST: psn 5, addr 0x2000, len 4096.
  - MIDDLE: psn 6, addr 0x3000, len 4096.
  - LAST: psn 7, addr 0x4000, len 1808.
  - `reth_len`=10000 on all three; `psn_next`=8.
- **PSN wrap:** `start_psn`=0xFFFFFE, `dma_length`=3×256, PMTU_LOG2=8 → PSNs 0xFFFFFE, 0xFFFFFF, 0x000000; `psn_next`=0x000001.
- **Backpressure:** hold `m_wr_ready`=0 for 5 cycles mid-transfer → all fields stable and no PSN skip; the remaining packets then issue one per cycle.
- **Ignored start and zero length:**
  - `start_transfer` pulsed during the 2nd of 3 packets → sequence unchanged and exactly one `done`.
  - `dma_length`=0 → one ONLY with pay_len 0.
- **Reset mid-transfer:** assert `rst` after the first handshake of a 3-packet transfer → `m_wr_valid`, `busy` = 0 immediately, no `done`. A subsequent start restarts cleanly at its own `start_psn`.

Source files
------------

// File: rtl/roce_write_segmenter.sv
`default_nettype none
// ============================================================================
// Module      : roce_write_segmenter
// Description : Splits one RDMA WRITE DMA request into per-packet RoCEv2 RC
//               work descriptors of at most one path MTU each. Every
//               descriptor carries its opcode (FIRST/MIDDLE/LAST/ONLY), PSN,
//               remote address and payload length. The PSN that follows the
//               last packet is reported once the transfer completes.
// Ports       : clk, rst               - clock, async active-high reset
//               start_transfer ..      - request strobe and request fields
//                                        (dma_length, rem_addr, r_key,
//                                        rem_qpn, start_psn)
//               m_wr_*                 - valid/ready descriptor stream
//               psn_next               - PSN after the last completed transfer
//               done, busy             - completion pulse, transfer in progress
// Revision    : 1.0 - initial release
// ============================================================================
module roce_write_segmenter #(
    parameter int PMTU_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_transfer,
    input  logic [31:0] dma_length,
    input  logic [63:0] rem_addr,
    input  logic [31:0] r_key,
    input  logic [23:0] rem_qpn,
    input  logic [23:0] start_psn,
    output logic        m_wr_valid,
    input  logic        m_wr_ready,
    output logic [7:0]  m_wr_opcode,
    output logic [23:0] m_wr_psn,
    output logic [63:0] m_wr_addr,
    output logic [31:0] m_wr_reth_len,
    output logic [31:0] m_wr_r_key,
    output logic [23:0] m_wr_qpn,
    output logic [12:0] m_wr_pay_len,
    output logic        m_wr_ack_req,
    output logic [23:0] psn_next,
    output logic        done,
    output logic        busy
);

    localparam logic [31:0] c_pmtu_bytes = 32'd1 << PMTU_LOG2;
    localparam logic [12:0] c_pmtu_len   = 13'd1 << PMTU_LOG2;

    localparam logic [7:0] c_op_first  = 8'h06;
    localparam logic [7:0] c_op_middle = 8'h07;
    localparam logic [7:0] c_op_last   = 8'h08;
    localparam logic [7:0] c_op_only   = 8'h0A;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t      r_state_q,    r_state_d;
    logic [31:0] r_rem_q,      r_rem_d;
    logic [63:0] r_addr_q,     r_addr_d;
    logic [23:0] r_psn_q,      r_psn_d;
    logic        r_first_q,    r_first_d;
    logic [31:0] r_reth_q,     r_reth_d;
    logic [31:0] r_rkey_q,     r_rkey_d;
    logic [23:0] r_qpn_q,      r_qpn_d;
    logic [23:0] r_psn_next_q, r_psn_next_d;
    logic        r_done_q,     r_done_d;

    logic        w_valid;
    logic        w_last;
    logic [12:0] w_pay_len;
    logic [7:0]  w_opcode;

    // Everything presented downstream is derived from registered state only,
    // so m_wr_ready never reaches an output combinationally and the fields
    // stay stable while the descriptor is stalled.
    assign w_valid   = (r_state_q == S_ISSUE);
    assign w_last    = (r_rem_q <= c_pmtu_bytes);
    // When last, remaining fits in 13 bits because it is <= 4096.
    assign w_pay_len = w_last ? r_rem_q[12:0] : c_pmtu_len;

    always_comb begin
        w_opcode = c_op_middle;
        if (r_first_q && w_last) begin
            w_opcode = c_op_only;
        end else if (r_first_q) begin
            w_opcode = c_op_first;
        end else if (w_last) begin
            w_opcode = c_op_last;
        end
    end

    always_comb begin
        r_state_d    = r_state_q;
        r_rem_d      = r_rem_q;
        r_addr_d     = r_addr_q;
        r_psn_d      = r_psn_q;
        r_first_d    = r_first_q;
        r_reth_d     = r_reth_q;
        r_rkey_d     = r_rkey_q;
        r_qpn_d      = r_qpn_q;
        r_psn_next_d = r_psn_next_q;
        r_done_d     = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (start_transfer) begin
                    r_state_d = S_ISSUE;
                    r_rem_d   = dma_length;
                    r_addr_d  = rem_addr;
                    r_psn_d   = start_psn;
                    r_first_d = 1'b1;
                    r_reth_d  = dma_length;
                    r_rkey_d  = r_key;
                    r_qpn_d   = rem_qpn;
                end
            end
            S_ISSUE: begin
                if (m_wr_ready) begin
                    r_rem_d   = r_rem_q - {19'd0, w_pay_len};
                    r_addr_d  = r_addr_q + {51'd0, w_pay_len};
                    r_psn_d   = r_psn_q + 24'd1;
                    r_first_d = 1'b0;
                    if (w_last) begin
                        r_psn_next_d = r_psn_q + 24'd1;
                        r_done_d     = 1'b1;
                        r_state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                r_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_rem_q      <= 32'd0;
            r_addr_q     <= 64'd0;
            r_psn_q      <= 24'd0;
            r_first_q    <= 1'b0;
            r_reth_q     <= 32'd0;
            r_rkey_q     <= 32'd0;
            r_qpn_q      <= 24'd0;
            r_psn_next_q <= 24'd0;
            r_done_q     <= 1'b0;
        end else begin
            r_state_q    <= r_state_d;
            r_rem_q      <= r_rem_d;
            r_addr_q     <= r_addr_d;
            r_psn_q      <= r_psn_d;
            r_first_q    <= r_first_d;
            r_reth_q     <= r_reth_d;
            r_rkey_q     <= r_rkey_d;
            r_qpn_q      <= r_qpn_d;
            r_psn_next_q <= r_psn_next_d;
            r_done_q     <= r_done_d;
        end
    end

    // Descriptor fields read as zero whenever no descriptor is offered, so an
    // idle or freshly reset block shows an all-zero stream.
    assign m_wr_valid    = w_valid;
    assign m_wr_opcode   = w_valid ? w_opcode  : 8'd0;
    assign m_wr_psn      = w_valid ? r_psn_q   : 24'd0;
    assign m_wr_addr     = w_valid ? r_addr_q  : 64'd0;
    assign m_wr_reth_len = w_valid ? r_reth_q  : 32'd0;
    assign m_wr_r_key    = w_valid ? r_rkey_q  : 32'd0;
    assign m_wr_qpn      = w_valid ? r_qpn_q   : 24'd0;
    assign m_wr_pay_len  = w_valid ? w_pay_len : 13'd0;
    assign m_wr_ack_req  = w_valid & w_last;
    assign psn_next      = r_psn_next_q;
    assign done          = r_done_q;
    assign busy          = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_roce_write_segmenter.sv
`default_nettype none
// ============================================================================
// Module      : tb_roce_write_segmenter
// Description : Directed self-checking bench for roce_write_segmenter. Two
//               instances (PMTU 4096 and PMTU 256) share the request inputs;
//               r_sel chooses which one is started and observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roce_write_segmenter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_start = 1'b0;
    logic        r_sel = 1'b0;
    logic [31:0] r_len = 32'd0;
    logic [63:0] r_addr = 64'd0;
    logic [31:0] r_rkey = 32'd0;
    logic [23:0] r_qpn = 24'd0;
    logic [23:0] r_spsn = 24'd0;
    logic        r_ready = 1'b1;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // Outputs of both instances, index 0 = PMTU 4096, index 1 = PMTU 256
    logic        w_valid   [2];
    logic [7:0]  w_op      [2];
    logic [23:0] w_psn     [2];
    logic [63:0] w_addr    [2];
    logic [31:0] w_reth    [2];
    logic [31:0] w_rk      [2];
    logic [23:0] w_qp      [2];
    logic [12:0] w_pay     [2];
    logic        w_ack     [2];
    logic [23:0] w_pnext   [2];
    logic        w_done    [2];
    logic        w_busy    [2];

    roce_write_segmenter #(.PMTU_LOG2(12)) dut12 (
        .clk(clk), .rst(rst), .start_transfer(r_start & ~r_sel),
        .dma_length(r_len), .rem_addr(r_addr), .r_key(r_rkey),
        .rem_qpn(r_qpn), .start_psn(r_spsn),
        .m_wr_valid(w_valid[0]), .m_wr_ready(r_ready),
        .m_wr_opcode(w_op[0]), .m_wr_psn(w_psn[0]), .m_wr_addr(w_addr[0]),
        .m_wr_reth_len(w_reth[0]), .m_wr_r_key(w_rk[0]), .m_wr_qpn(w_qp[0]),
        .m_wr_pay_len(w_pay[0]), .m_wr_ack_req(w_ack[0]),
        .psn_next(w_pnext[0]), .done(w_done[0]), .busy(w_busy[0])
    );

    roce_write_segmenter #(.PMTU_LOG2(8)) dut8 (
        .clk(clk), .rst(rst), .start_transfer(r_start & r_sel),
        .dma_length(r_len), .rem_addr(r_addr), .r_key(r_rkey),
        .rem_qpn(r_qpn), .start_psn(r_spsn),
        .m_wr_valid(w_valid[1]), .m_wr_ready(r_ready),
        .m_wr_opcode(w_op[1]), .m_wr_psn(w_psn[1]), .m_wr_addr(w_addr[1]),
        .m_wr_reth_len(w_reth[1]), .m_wr_r_key(w_rk[1]), .m_wr_qpn(w_qp[1]),
        .m_wr_pay_len(w_pay[1]), .m_wr_ack_req(w_ack[1]),
        .psn_next(w_pnext[1]), .done(w_done[1]), .busy(w_busy[1])
    );

    logic s;
    assign s = r_sel;

    always @(negedge clk) begin
        if (w_done[0] | w_done[1]) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic sel, input logic [31:0] len, input logic [63:0] addr,
                         input logic [23:0] spsn);
        r_sel  = sel;
        r_len  = len;
        r_addr = addr;
        r_spsn = spsn;
        r_start = 1'b1;
        tick();
        r_start = 1'b0;
    endtask

    // Waits (bounded) for a valid descriptor, then checks its fields.
    task automatic expect_desc(input string tag, input logic [7:0] op, input logic [23:0] psn,
                               input logic [63:0] addr, input logic [12:0] pay,
                               input logic [31:0] reth, input logic ack);
        int n = 0;
        while (!w_valid[s] && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {63'd0, w_valid[s]}, 64'd1);
        check({tag, "_op"},    {56'd0, w_op[s]},    {56'd0, op});
        check({tag, "_psn"},   {40'd0, w_psn[s]},   {40'd0, psn});
        check({tag, "_addr"},  w_addr[s],           addr);
        check({tag, "_pay"},   {51'd0, w_pay[s]},   {51'd0, pay});
        check({tag, "_reth"},  {32'd0, w_reth[s]},  {32'd0, reth});
        check({tag, "_ack"},   {63'd0, w_ack[s]},   {63'd0, ack});
    endtask

    task automatic expect_done(input string tag, input logic [23:0] pnext);
        check({tag, "_done"},  {63'd0, w_done[s]},  64'd1);
        check({tag, "_valid0"}, {63'd0, w_valid[s]}, 64'd0);
        check({tag, "_busy0"}, {63'd0, w_busy[s]},  64'd0);
        check({tag, "_pnext"}, {40'd0, w_pnext[s]}, {40'd0, pnext});
        tick();
        check({tag, "_done1cyc"}, {63'd0, w_done[s]}, 64'd0);
    endtask

    int d0;

    initial begin
        r_rkey = 32'hCAFE_0001;
        r_qpn  = 24'h00_0ABC;
        #23;
        // reset state
        check("rst_valid", {63'd0, w_valid[0]}, 64'd0);
        check("rst_busy",  {63'd0, w_busy[0]},  64'd0);
        check("rst_done",  {63'd0, w_done[0]},  64'd0);
        check("rst_pnext", {40'd0, w_pnext[0]}, 64'd0);
        check("rst_op",    {56'd0, w_op[0]},    64'd0);
        check("rst_pay",   {51'd0, w_pay[0]},   64'd0);
        check("rst_addr",  w_addr[0],           64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // single packet
        start(1'b0, 32'h1000, 64'h1_0000_0000, 24'h10);
        check("single_busy", {63'd0, w_busy[0]}, 64'd1);
        expect_desc("single", 8'h0A, 24'h10, 64'h1_0000_0000, 13'd4096, 32'h1000, 1'b1);
        check("single_rkey", {32'd0, w_rk[0]}, 64'hCAFE_0001);
        check("single_qpn",  {40'd0, w_qp[0]}, 64'h0ABC);
        tick();
        expect_done("single", 24'h11);

        // multi packet, back-to-back
        start(1'b0, 32'd10000, 64'h2000, 24'd5);
        expect_desc("multi_f", 8'h06, 24'd5, 64'h2000, 13'd4096, 32'd10000, 1'b0);
        tick();
        expect_desc("multi_m", 8'h07, 24'd6, 64'h3000, 13'd4096, 32'd10000, 1'b0);
        tick();
        expect_desc("multi_l", 8'h08, 24'd7, 64'h4000, 13'd1808, 32'd10000, 1'b1);
        tick();
        expect_done("multi", 24'd8);

        // PSN wrap and address wrap on the 256 B instance
        start(1'b1, 32'd768, 64'hFFFF_FFFF_FFFF_FF00, 24'hFFFFFE);
        expect_desc("wrap_f", 8'h06, 24'hFFFFFE, 64'hFFFF_FFFF_FFFF_FF00, 13'd256, 32'd768, 1'b0);
        tick();
        expect_desc("wrap_m", 8'h07, 24'hFFFFFF, 64'h0, 13'd256, 32'd768, 1'b0);
        tick();
        expect_desc("wrap_l", 8'h08, 24'h000000, 64'h100, 13'd256, 32'd768, 1'b1);
        tick();
        expect_done("wrap", 24'h000001);

        // backpressure
        start(1'b0, 32'd12388, 64'h5000, 24'h100);
        expect_desc("bp_f", 8'h06, 24'h100, 64'h5000, 13'd4096, 32'd12388, 1'b0);
        tick();
        r_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_desc("bp_hold", 8'h07, 24'h101, 64'h6000, 13'd4096, 32'd12388, 1'b0);
        end
        r_ready = 1'b1;
        tick();
        expect_desc("bp_m2", 8'h07, 24'h102, 64'h7000, 13'd4096, 32'd12388, 1'b0);
        tick();
        expect_desc("bp_l", 8'h08, 24'h103, 64'h8000, 13'd100, 32'd12388, 1'b1);
        tick();
        expect_done("bp", 24'h104);

        // start while busy is ignored
        d0 = done_cnt;
        start(1'b0, 32'd8193, 64'h9000, 24'h200);
        expect_desc("ign_f", 8'h06, 24'h200, 64'h9000, 13'd4096, 32'd8193, 1'b0);
        tick();
        expect_desc("ign_m", 8'h07, 24'h201, 64'hA000, 13'd4096, 32'd8193, 1'b0);
        start(1'b0, 32'd5, 64'hDEAD_0000, 24'h777);
        expect_desc("ign_l", 8'h08, 24'h202, 64'hB000, 13'd1, 32'd8193, 1'b1);
        tick();
        expect_done("ign", 24'h203);
        tick();
        check("ign_no_restart", {63'd0, w_valid[0]}, 64'd0);
        check("ign_done_count", 64'(done_cnt - d0), 64'd1);

        // zero length
        start(1'b0, 32'd0, 64'h1234, 24'h300);
        expect_desc("zero", 8'h0A, 24'h300, 64'h1234, 13'd0, 32'd0, 1'b1);
        tick();
        expect_done("zero", 24'h301);

        // reset mid-transfer
        d0 = done_cnt;
        start(1'b0, 32'd12288, 64'hC000, 24'h400);
        expect_desc("rst_f", 8'h06, 24'h400, 64'hC000, 13'd4096, 32'd12288, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        check("rstmid_valid", {63'd0, w_valid[0]}, 64'd0);
        check("rstmid_busy",  {63'd0, w_busy[0]},  64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
        check("rstmid_pnext", {40'd0, w_pnext[0]}, 64'd0);
        start(1'b0, 32'd100, 64'hE000, 24'h50);
        expect_desc("restart", 8'h0A, 24'h50, 64'hE000, 13'd100, 32'd100, 1'b1);
        tick();
        expect_done("restart", 24'h51);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
